sr_ff_bank: RTL and testbench
=============================

Name: sr_ff_bank

Overview:
Parametrised bank of WIDTH independent synchronous set/reset flip-flops sharing one clock, enable and parallel-load path. The conflict policy for s=r=1 is selectable; mode 0 is reset-dominant. Adds per-channel registered edge pulses and a sticky, saturating conflict monitor. Used wherever status bits are set and cleared by separate event sources, such as interrupt pending bits and mode latches.

Parameters:
WIDTH, 8, number of channels (1..64)
CONFLICT_MODE, 0, s=r=1 policy: 0 reset-dominant (q->0), 1 set-dominant (q->1), 2 toggle (JK), 3 hold
RST_VAL, 0, WIDTH-bit value loaded into q on reset
CNT_W, 8, conflict counter width (>=1)
FILT_LEN, 2, stable cycles required by the input filter (>=1); used only when SR_FF_BANK_FILTER_EN is defined

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  synchronous enable for s/r action
s  input  WIDTH  per-channel set request
r  input  WIDTH  per-channel reset request
ld  input  1  synchronous parallel load
ld_data  input  WIDTH  load value
clr_conflict  input  1  synchronous clear of conflict monitor
q  output  WIDTH  flip-flop state
rise  output  WIDTH  one-cycle pulse, channel went 0->1
fall  output  WIDTH  one-cycle pulse, channel went 1->0
conflict  output  1  sticky flag: an s=r=1 event occurred
conflict_cnt  output  CNT_W  saturating count of conflict cycles

Behaviour:
- Reset (async, active-high): q=RST_VAL, rise=0, fall=0, conflict=0, conflict_cnt=0, filter state cleared. Reset mid-operation aborts everything immediately; no edge pulses are generated by reset or by its release.
- Priority per clock edge: rst > ld > en. ld=1 sets q<=ld_data regardless of en, s and r.
- ld=0, en=0: q holds.
- ld=0, en=1, per channel i, using effective inputs se/re (raw s/r, or filtered values when the filter is enabled):
  - 00: hold.
  - 01: q<=0.
  - 10: q<=1.
  - 11: per CONFLICT_MODE: 0 -> q<=0; 1 -> q<=1; 2 -> q<=~q; 3 -> hold.
- Latency: one clock from effective input to q.
- Edge pulses: registered on the same edge as q updates. rise[i]=next_q[i]&~q[i] and fall[i]=~next_q[i]&q[i], so a pulse coincides with the cycle the new q is visible. Edge pulses are produced for ld-caused changes too.
- Conflict event: a cycle with en=1, ld=0 and any bit of (se&re) set counts once, irrespective of how many channels conflict.
  - On an event: conflict<=1 and conflict_cnt<=conflict_cnt+1, saturating at 2^CNT_W-1 with no wrap.
- clr_conflict=1 with no event that cycle: conflict<=0, conflict_cnt<=0.
- clr_conflict=1 with an event in the same cycle: the event wins, giving conflict=1, conflict_cnt=1.
- Conflicts are counted in every CONFLICT_MODE, including 3.

Optional Feature:
Macro SR_FF_BANK_FILTER_EN.
- Defined: each s and r bit passes through a deglitch filter. The filtered bit adopts the raw value only after the raw value has differed from the filtered value for FILT_LEN consecutive clocks; any reversion restarts the count. Filtered bits reset to 0.
  - Filters run continuously, independent of en and ld.
  - Input-to-q latency becomes FILT_LEN+1 clocks.
  - Conflict detection uses the filtered values.
  - ld_data is not filtered.
- Undefined: no filter logic; se=s, re=r; FILT_LEN is ignored.

Test Plan:
- Reset/hold (WIDTH=8, RST_VAL=8'hA5): assert rst mid-cycle -> q=8'hA5 immediately, rise=fall=0; release, en=1, s=r=0 for 5 clocks -> q stays 8'hA5, no pulses.
- Set/reset per channel (mode 0): en=1, s=8'h0F, r=8'hF0 from q=8'hA5 -> next q=8'h0F, rise=8'h0A, fall=8'hA0 for exactly one cycle.
- Conflict modes: q=8'h0F, s=r=8'h03, en=1 -> q becomes 8'h0C (mode 0), 8'h0F (mode 1), 8'h0C (mode 2), 8'h0F (mode 3); in every mode conflict=1 and conflict_cnt=1.
- Saturation/clear (CNT_W=2): 5 consecutive conflict cycles -> conflict_cnt=3; clr_conflict alone -> 0/0; clr_conflict together with a conflict -> conflict=1, conflict_cnt=1.
- Priority: ld=1 with ld_data=8'h3C, en=1, s=8'hFF -> q=8'h3C, no count; en=0 with s=8'hFF, ld=0 -> q unchanged.
- Filter (macro defined, FILT_LEN=2): s[0] high for 1 clock -> q[0] unchanged; s[0] high for 2 clocks -> q[0]=1 three clocks after s[0] first rises.

Source files
------------

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH set/reset flip-flops with a selectable s=r=1 policy, edge pulses and a conflict
// monitor. Define SR_FF_BANK_FILTER_EN to add a FILT_LEN-cycle deglitch filter on every s/r bit.
module sr_ff_bank #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] RST_VAL       = '0,
    parameter int unsigned      CNT_W         = 8,
    parameter int unsigned      FILT_LEN      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("sr_ff_bank: WIDTH must be in 1..64");
    end
    if (CONFLICT_MODE > 3) begin : g_bad_mode
        $error("sr_ff_bank: CONFLICT_MODE must be in 0..3");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sr_ff_bank: CNT_W must be at least 1");
    end
    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("sr_ff_bank: FILT_LEN must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] se;
    logic [WIDTH-1:0] re;

`ifdef SR_FF_BANK_FILTER_EN
    // Counter holds how many consecutive clocks raw has differed from filtered, up to FILT_LEN-1.
    localparam int unsigned    FCW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FCW-1:0] CNT_LAST = FCW'(FILT_LEN - 1);

    // s occupies the low half and r the high half, so both share one filter loop.
    logic [2*WIDTH-1:0] raw;
    logic [2*WIDTH-1:0] filt_q;
    logic [2*WIDTH-1:0] filt_d;
    logic [FCW-1:0]     fcnt_q [2*WIDTH];
    logic [FCW-1:0]     fcnt_d [2*WIDTH];

    assign raw = {r, s};

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            fcnt_d[i] = '0;
            if (raw[i] != filt_q[i]) begin
                if (fcnt_q[i] == CNT_LAST) begin
                    filt_d[i] = raw[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < 2 * WIDTH; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 2 * WIDTH; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    assign se = filt_q[WIDTH-1:0];
    assign re = filt_q[2*WIDTH-1:WIDTH];
`else
    assign se = s;
    assign re = r;
`endif

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             conflict_q;
    logic             conflict_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cfl_event;

    always_comb begin
        q_d       = q_q;
        cfl_event = 1'b0;
        if (ld) begin
            q_d = ld_data;
        end else if (en) begin
            cfl_event = |(se & re);
            for (int i = 0; i < WIDTH; i++) begin
                unique case ({se[i], re[i]})
                    2'b00: q_d[i] = q_q[i];
                    2'b01: q_d[i] = 1'b0;
                    2'b10: q_d[i] = 1'b1;
                    2'b11: begin
                        case (CONFLICT_MODE)
                            0:       q_d[i] = 1'b0;
                            1:       q_d[i] = 1'b1;
                            2:       q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    default: q_d[i] = q_q[i];
                endcase
            end
        end

        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;

        conflict_d = conflict_q;
        cnt_d      = cnt_q;
        // A conflict in the same cycle as a clear restarts the count at one rather than zero.
        if (cfl_event) begin
            conflict_d = 1'b1;
            if (clr_conflict) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clr_conflict) begin
            conflict_d = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= RST_VAL;
            rise_q     <= '0;
            fall_q     <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q            = q_q;
    assign rise         = rise_q;
    assign fall         = fall_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: one instance per conflict mode, all driven in parallel and
// compared against a behavioural model; honours SR_FF_BANK_FILTER_EN when defined.
module tb_sr_ff_bank;

    localparam int unsigned WIDTH    = 8;
    localparam logic [7:0]  RST_VAL  = 8'hA5;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned FILT_LEN = 2;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             ld;
    logic             clr_conflict;
    logic [7:0]       s;
    logic [7:0]       r;
    logic [7:0]       ld_data;

    logic [7:0]       q_w    [4];
    logic [7:0]       rise_w [4];
    logic [7:0]       fall_w [4];
    logic             conf_w [4];
    logic [CNT_W-1:0] cnt_w  [4];

    int checks   = 0;
    int failures = 0;

    // Reference model state, one entry per conflict mode.
    logic [7:0] mq    [4];
    logic [7:0] mrise [4];
    logic [7:0] mfall [4];
    logic       mconf [4];
    int         mcnt  [4];
    logic [7:0] fs;
    logic [7:0] fr;
    int         fcnt_s [8];
    int         fcnt_r [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_ff_bank #(
            .WIDTH        (WIDTH),
            .CONFLICT_MODE(g),
            .RST_VAL      (RST_VAL),
            .CNT_W        (CNT_W),
            .FILT_LEN     (FILT_LEN)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .s           (s),
            .r           (r),
            .ld          (ld),
            .ld_data     (ld_data),
            .clr_conflict(clr_conflict),
            .q           (q_w[g]),
            .rise        (rise_w[g]),
            .fall        (fall_w[g]),
            .conflict    (conf_w[g]),
            .conflict_cnt(cnt_w[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            mq[m]    = RST_VAL;
            mrise[m] = '0;
            mfall[m] = '0;
            mconf[m] = 1'b0;
            mcnt[m]  = 0;
        end
        fs = '0;
        fr = '0;
        for (int i = 0; i < 8; i++) begin
            fcnt_s[i] = 0;
            fcnt_r[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [7:0] se;
        logic [7:0] re;
        logic [7:0] nq;
        bit         ev;
`ifdef SR_FF_BANK_FILTER_EN
        se = fs;
        re = fr;
`else
        se = s;
        re = r;
`endif
        ev = !ld && en && ((se & re) != 8'h00);
        for (int m = 0; m < 4; m++) begin
            nq = mq[m];
            if (ld) begin
                nq = ld_data;
            end else if (en) begin
                for (int i = 0; i < 8; i++) begin
                    if (se[i] && !re[i]) nq[i] = 1'b1;
                    else if (!se[i] && re[i]) nq[i] = 1'b0;
                    else if (se[i] && re[i]) begin
                        if (m == 0) nq[i] = 1'b0;
                        else if (m == 1) nq[i] = 1'b1;
                        else if (m == 2) nq[i] = !mq[m][i];
                    end
                end
            end
            if (ev) begin
                mconf[m] = 1'b1;
                mcnt[m]  = clr_conflict ? 1 : ((mcnt[m] + 1 > CNT_MAX) ? CNT_MAX : mcnt[m] + 1);
            end else if (clr_conflict) begin
                mconf[m] = 1'b0;
                mcnt[m]  = 0;
            end
            mrise[m] = nq & ~mq[m];
            mfall[m] = ~nq & mq[m];
            mq[m]    = nq;
        end
        for (int i = 0; i < 8; i++) begin
            if (s[i] != fs[i]) begin
                fcnt_s[i]++;
                if (fcnt_s[i] >= FILT_LEN) begin
                    fs[i]     = s[i];
                    fcnt_s[i] = 0;
                end
            end else begin
                fcnt_s[i] = 0;
            end
            if (r[i] != fr[i]) begin
                fcnt_r[i]++;
                if (fcnt_r[i] >= FILT_LEN) begin
                    fr[i]     = r[i];
                    fcnt_r[i] = 0;
                end
            end else begin
                fcnt_r[i] = 0;
            end
        end
    endtask

    task automatic chk_all(input string tag);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s.m%0d.q", tag, m), 64'(q_w[m]), 64'(mq[m]));
            chk($sformatf("%s.m%0d.rise", tag, m), 64'(rise_w[m]), 64'(mrise[m]));
            chk($sformatf("%s.m%0d.fall", tag, m), 64'(fall_w[m]), 64'(mfall[m]));
            chk($sformatf("%s.m%0d.conflict", tag, m), 64'(conf_w[m]), 64'(mconf[m]));
            chk($sformatf("%s.m%0d.cnt", tag, m), 64'(cnt_w[m]), 64'(mcnt[m]));
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst          = 1'b0;
        en           = 1'b0;
        ld           = 1'b0;
        clr_conflict = 1'b0;
        s            = '0;
        r            = '0;
        ld_data      = '0;

        // Async reset asserted mid-cycle takes effect without a clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all("reset");
        chk("reset.q_lit", 64'(q_w[0]), 64'h A5);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        repeat (5) step("hold");
        chk("hold.q_lit", 64'(q_w[3]), 64'h A5);

        s = 8'h0F;
        r = 8'hF0;
        step("setrst");
`ifndef SR_FF_BANK_FILTER_EN
        chk("setrst.q_lit", 64'(q_w[0]), 64'h0F);
        chk("setrst.rise_lit", 64'(rise_w[0]), 64'h0A);
        chk("setrst.fall_lit", 64'(fall_w[0]), 64'hA0);
`endif
        step("setrst_pulse_end");

        s = 8'h03;
        r = 8'h03;
        step("modes");
`ifndef SR_FF_BANK_FILTER_EN
        chk("modes.q0_lit", 64'(q_w[0]), 64'h0C);
        chk("modes.q1_lit", 64'(q_w[1]), 64'h0F);
        chk("modes.q2_lit", 64'(q_w[2]), 64'h0C);
        chk("modes.q3_lit", 64'(q_w[3]), 64'h0F);
        chk("modes.cnt3_lit", 64'(cnt_w[3]), 64'd1);
`endif

        s            = '0;
        r            = '0;
        clr_conflict = 1'b1;
        step("clear");
        clr_conflict = 1'b0;
        s            = 8'h01;
        r            = 8'h01;
        repeat (5) step("saturate");
`ifndef SR_FF_BANK_FILTER_EN
        chk("saturate.cnt_lit", 64'(cnt_w[0]), 64'd3);
`endif
        s            = '0;
        r            = '0;
        clr_conflict = 1'b1;
        step("clr_alone");
`ifndef SR_FF_BANK_FILTER_EN
        chk("clr_alone.cnt_lit", 64'(cnt_w[1]), 64'd0);
        chk("clr_alone.conf_lit", 64'(conf_w[1]), 64'd0);
`endif
        s = 8'h01;
        r = 8'h01;
        step("clr_with_event");
`ifndef SR_FF_BANK_FILTER_EN
        chk("clr_with_event.cnt_lit", 64'(cnt_w[2]), 64'd1);
        chk("clr_with_event.conf_lit", 64'(conf_w[2]), 64'd1);
`endif
        s = '0;
        r = '0;
        repeat (3) step("settle");
        clr_conflict = 1'b0;

        ld      = 1'b1;
        ld_data = 8'h3C;
        s       = 8'hFF;
        r       = 8'hFF;
        step("load");
`ifndef SR_FF_BANK_FILTER_EN
        chk("load.q_lit", 64'(q_w[0]), 64'h3C);
        chk("load.cnt_lit", 64'(cnt_w[0]), 64'd0);
`endif
        ld = 1'b0;
        en = 1'b0;
        r  = '0;
        step("en_off");
        chk("en_off.q_lit", 64'(q_w[1]), 64'h3C);

`ifdef SR_FF_BANK_FILTER_EN
        en = 1'b1;
        s  = '0;
        repeat (4) step("filt_settle");
        ld      = 1'b1;
        ld_data = 8'h00;
        step("filt_load");
        ld   = 1'b0;
        s[0] = 1'b1;
        step("filt_glitch");
        s[0] = 1'b0;
        repeat (4) step("filt_glitch_after");
        chk("filt_glitch.q0_lit", 64'(q_w[0][0]), 64'd0);
        s[0] = 1'b1;
        step("filt_pulse1");
        step("filt_pulse2");
        s[0] = 1'b0;
        step("filt_pulse3");
        chk("filt_pulse.q0_lit", 64'(q_w[0][0]), 64'd1);
`endif

        for (int n = 0; n < 300; n++) begin
            en           = ($urandom_range(0, 3) != 0);
            ld           = ($urandom_range(0, 7) == 0);
            ld_data      = 8'($urandom);
            s            = 8'($urandom);
            r            = 8'($urandom);
            if ($urandom_range(0, 1) == 1) r = r & ~s;
            clr_conflict = ($urandom_range(0, 5) == 0);
            step("rand");
            if (n == 150) begin
                #3;
                rst = 1'b1;
                model_reset();
                #1;
                chk_all("rand_reset");
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
